// File: rtl/ica_pkg.sv
// Shared types and widths for the FastICA output path.
package ica_pkg;
    localparam int ICA_DATA_W = 26;
    localparam int ICA_NUM_CH = 4;
    localparam int ICA_VEC_W  = ICA_DATA_W * ICA_NUM_CH;

    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [1:0] ch_t;
endpackage

// File: rtl/ica_vec_fifo.sv
// Register FIFO of packed {y4,y3,y2,y1} vectors with an explicit occupancy counter.
module ica_vec_fifo
    import ica_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [ICA_VEC_W-1:0]   push_data,
    input  logic                   pop,
    output logic [ICA_VEC_W-1:0]   head,
    output logic [ICA_VEC_W-1:0]   head_next,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [ICA_VEC_W-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PW'(1)];
endmodule

// File: rtl/ica_output_serializer.sv
// Buffers separated-source vectors and streams them one scaled channel per beat.
// Build option: ICA_OUT_SAT_EN selects saturating narrowing and a sticky sat_flag.
//
// state | meaning
// IDLE  | nothing to send, out_valid low
// SEND  | presenting head vector channel ch_cnt
module ica_output_serializer
    import ica_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OUT_W = 16,
    parameter int SHIFT = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [ICA_DATA_W-1:0] y1,
    input  logic signed [ICA_DATA_W-1:0] y2,
    input  logic signed [ICA_DATA_W-1:0] y3,
    input  logic signed [ICA_DATA_W-1:0] y4,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_W-1:0]      out_data,
    output ch_t                          out_ch,
    output logic                         out_last,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         sat_flag
);
    localparam int LW = $clog2(DEPTH) + 1;

    state_t                       state;
    ch_t                          ch_cnt;
    logic [ICA_VEC_W-1:0]         head, head_next, in_vec, next_vec, ld_vec;
    logic                         push, pop, more, ld_en;
    ch_t                          ld_ch;
    logic signed [ICA_DATA_W-1:0] ld_sample, shifted;
    logic signed [OUT_W-1:0]      ld_data;

    ica_vec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_vec),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .level     (level)
    );

    assign in_vec   = {y4, y3, y2, y1};
    assign in_ready = (level != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == SEND) && out_ready && (ch_cnt == 2'd3);
    assign more     = (level > LW'(1)) || push;
    // A lone head being popped while a new vector lands: forward it straight from the inputs.
    assign next_vec = (level == LW'(1)) ? in_vec : head_next;
    assign ld_en    = ((state == IDLE) && (level != '0)) || ((state == SEND) && out_ready);
    assign out_ch   = ch_cnt;

    always_comb begin
        ld_vec = head;
        ld_ch  = '0;
        if (state == SEND) begin
            if (ch_cnt == 2'd3) ld_vec = next_vec;
            else                ld_ch  = ch_cnt + 2'd1;
        end
        ld_sample = ld_vec[ICA_DATA_W*ld_ch +: ICA_DATA_W];
        shifted   = ld_sample >>> SHIFT;
    end

`ifdef ICA_OUT_SAT_EN
    localparam logic signed [ICA_DATA_W-1:0] SAT_MAX = ICA_DATA_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ICA_DATA_W-1:0] SAT_MIN = ~SAT_MAX;

    logic ld_clip, out_clip;

    always_comb begin
        ld_clip = 1'b0;
        ld_data = OUT_W'(shifted);
        if (shifted > SAT_MAX) begin
            ld_clip = 1'b1;
            ld_data = OUT_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            ld_clip = 1'b1;
            ld_data = OUT_W'(SAT_MIN);
        end
    end

    // The clip bit travels with the beat so only accepted beats set the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_clip <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (ld_en) out_clip <= ld_clip;
            if (out_valid && out_ready && out_clip) sat_flag <= 1'b1;
        end
    end
`else
    assign ld_data  = OUT_W'(shifted);
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (pop && !more) begin
            state     <= IDLE;
            ch_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (ld_en) begin
            state     <= SEND;
            ch_cnt    <= ld_ch;
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_last  <= (ld_ch == 2'd3);
        end
    end
endmodule

// File: tb/tb_ica_output_serializer.sv
// Directed bench for ica_output_serializer; second instance uses SHIFT=0 for narrowing checks.
module tb_ica_output_serializer;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, out_valid, out_ready, out_last, sat_flag;
    logic signed [25:0] y1, y2, y3, y4;
    logic signed [15:0] out_data;
    logic [1:0]         out_ch;
    logic [2:0]         level;

    logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_sat_flag;
    logic signed [25:0] b_y1, b_y2, b_y3, b_y4;
    logic signed [15:0] b_out_data;
    logic [1:0]         b_out_ch;
    logic [2:0]         b_level;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ica_output_serializer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .level(level), .sat_flag(sat_flag)
    );

    ica_output_serializer #(.SHIFT(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .y1(b_y1), .y2(b_y2), .y3(b_y3), .y4(b_y4),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_last(b_out_last), .level(b_level), .sat_flag(b_sat_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector n scales (SHIFT=10) to beats 10n+1 .. 10n+4.
    task automatic set_vec(input int n);
        y1 = 26'((10*n + 1) * 1024);
        y2 = 26'((10*n + 2) * 1024);
        y3 = 26'((10*n + 3) * 1024);
        y4 = 26'((10*n + 4) * 1024);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #2;
        vectors++;
        if ({out_valid, out_ch, out_last, out_data, level, sat_flag} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%0b ch=%0d last=%0b data=%0d level=%0d sat=%0b want all 0",
                     out_valid, out_ch, out_last, out_data, level, sat_flag);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        logic signed [15:0] exp_d [4] = '{16'sd1, -16'sd1, 16'sd2, 16'sd0};
        out_ready = 1'b1;
        y1 = 26'sd1024; y2 = -26'sd1024; y3 = 26'sd2048; y4 = 26'sd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd1) begin
            miscompares++;
            $display("FAIL single_latency: got out_valid=%0b level=%0d want 0 1", out_valid, level);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({out_valid, out_ch, out_last, out_data} !== {1'b1, 2'(i), (i == 3), exp_d[i]}) begin
                miscompares++;
                $display("FAIL single_beat%0d: got v=%0b ch=%0d last=%0b data=%0d want v=1 ch=%0d last=%0b data=%0d",
                         i, out_valid, out_ch, out_last, out_data, i, (i == 3), exp_d[i]);
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            miscompares++;
            $display("FAIL single_done: got out_valid=%0b level=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_fill_and_full_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_vec(i);
            in_valid = 1'b1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready push%0d: got %0b want 1", i, in_ready);
            end
            tick();
        end
        set_vec(4);
        for (int s = 0; s < 3; s++) begin
            vectors++;
            if ({in_ready, level, out_valid, out_ch, out_data} !== {1'b0, 3'd4, 1'b1, 2'd0, 16'sd1}) begin
                miscompares++;
                $display("FAIL fill_full_hold%0d: got in_ready=%0b level=%0d v=%0b ch=%0d data=%0d want 0 4 1 0 1",
                         s, in_ready, level, out_valid, out_ch, out_data);
            end
            if (s < 2) tick();
        end
        out_ready = 1'b1;
        for (int c = 1; c < 4; c++) begin
            tick();
            vectors++;
            if ({out_ch, out_last, out_data, level} !== {2'(c), (c == 3), 16'(c + 1), 3'd4}) begin
                miscompares++;
                $display("FAIL fill_frame0_ch%0d: got ch=%0d last=%0b data=%0d level=%0d want ch=%0d data=%0d level=4",
                         c, out_ch, out_last, out_data, level, c, c + 1);
            end
        end
        tick();
        vectors++;
        if ({level, in_ready, out_valid, out_ch, out_data} !== {3'd3, 1'b1, 1'b1, 2'd0, 16'sd11}) begin
            miscompares++;
            $display("FAIL full_pop_refuse: got level=%0d in_ready=%0b v=%0b ch=%0d data=%0d want 3 1 1 0 11",
                     level, in_ready, out_valid, out_ch, out_data);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({level, out_ch, out_data} !== {3'd4, 2'd1, 16'sd12}) begin
            miscompares++;
            $display("FAIL full_push_next: got level=%0d ch=%0d data=%0d want 4 1 12", level, out_ch, out_data);
        end
        tick();
        for (int v = 1; v < 5; v++) begin
            for (int c = (v == 1) ? 2 : 0; c < 4; c++) begin
                vectors++;
                if ({out_valid, out_ch, out_last, out_data} !== {1'b1, 2'(c), (c == 3), 16'(10*v + c + 1)}) begin
                    miscompares++;
                    $display("FAIL drain v%0d ch%0d: got v=%0b ch=%0d last=%0b data=%0d want data=%0d",
                             v, c, out_valid, out_ch, out_last, out_data, 10*v + c + 1);
                end
                tick();
            end
        end
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_empty: got out_valid=%0b level=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_stall_toggle();
        out_ready = 1'b0;
        set_vec(5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        // Stall first, then accept: each channel is shown for two cycles.
        for (int t = 0; t < 8; t++) begin
            out_ready = (t % 2 == 1);
            vectors++;
            if ({out_valid, out_ch, out_last, out_data} !== {1'b1, 2'(t/2), (t/2 == 3), 16'(51 + t/2)}) begin
                miscompares++;
                $display("FAIL stall_t%0d: got v=%0b ch=%0d last=%0b data=%0d want ch=%0d data=%0d",
                         t, out_valid, out_ch, out_last, out_data, t/2, 51 + t/2);
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            miscompares++;
            $display("FAIL stall_done: got out_valid=%0b level=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_narrowing();
        logic signed [15:0] exp_d [4];
        logic               exp_sat;
`ifdef ICA_OUT_SAT_EN
        exp_d = '{16'sd32767, -16'sd32768, 16'sd100, -16'sd5};
        exp_sat = 1'b1;
`else
        exp_d = '{-16'sd1, 16'sd0, 16'sd100, -16'sd5};
        exp_sat = 1'b0;
`endif
        b_out_ready = 1'b1;
        b_y1 = 26'sd33554431; b_y2 = -26'sd33554432; b_y3 = 26'sd100; b_y4 = -26'sd5;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        tick();
        vectors++;
        if (b_sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_before_handshake: got %0b want 0", b_sat_flag);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({b_out_valid, b_out_ch, b_out_data} !== {1'b1, 2'(i), exp_d[i]}) begin
                miscompares++;
                $display("FAIL narrow_beat%0d: got v=%0b ch=%0d data=%0d want ch=%0d data=%0d",
                         i, b_out_valid, b_out_ch, b_out_data, i, exp_d[i]);
            end
            tick();
        end
        vectors++;
        if (b_sat_flag !== exp_sat || b_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_flag: got sat=%0b v=%0b want sat=%0b v=0", b_sat_flag, b_out_valid, exp_sat);
        end
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        set_vec(6);
        in_valid = 1'b1;
        tick();
        set_vec(7);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if ({out_ch, out_data, level} !== {2'd2, 16'sd63, 3'd2}) begin
            miscompares++;
            $display("FAIL midreset_pre: got ch=%0d data=%0d level=%0d want 2 63 2", out_ch, out_data, level);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_ch, out_last, out_data, level, b_sat_flag} !== 24'd0) begin
            miscompares++;
            $display("FAIL midreset_clear: got v=%0b ch=%0d last=%0b data=%0d level=%0d sat=%0b want all 0",
                     out_valid, out_ch, out_last, out_data, level, b_sat_flag);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        set_vec(8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if ({out_valid, out_ch, out_data, level} !== {1'b1, 2'd0, 16'sd81, 3'd1}) begin
            miscompares++;
            $display("FAIL midreset_restart: got v=%0b ch=%0d data=%0d level=%0d want 1 0 81 1",
                     out_valid, out_ch, out_data, level);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; y1 = '0; y2 = '0; y3 = '0; y4 = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_y1 = '0; b_y2 = '0; b_y3 = '0; b_y4 = '0;
        test_reset();
        test_single();
        test_fill_and_full_pop();
        test_stall_toggle();
        test_narrowing();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ica_output_serializer.md
# ica_output_serializer

Downstream stage of the FastICA processor. Captures each separated-source vector (four 26-bit signed samples y1..y4) into a small vector FIFO, scales it to a narrower output word, and streams it out one channel per beat over a valid/ready interface, with an end-of-frame marker on channel 4. It decouples the FastICA block's burst output from a slower consumer such as a DAC or host link.

## Interface
Parameters:
- DEPTH, 4: FIFO depth in vectors; power of two, 2..16.
- OUT_W, 16: output sample width, signed.
- SHIFT, 10: arithmetic right shift applied to each 26-bit sample before narrowing; 0..25.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  y1..y4 hold a new vector.
- in_ready  out  1  block can accept a vector (FIFO not full).
- y1, y2, y3, y4  in  26 each  signed separated samples.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the current beat.
- out_data  out  OUT_W  signed scaled sample.
- out_ch  out  2  channel index of out_data, 0..3.
- out_last  out  1  high on the channel-3 beat.
- level  out  $clog2(DEPTH)+1  vectors stored, including the one being sent.
- sat_flag  out  1  sticky: some sample clipped (ICA_OUT_SAT_EN only; else tied 0).

## Operation
- Input push: vector written when in_valid && in_ready at a rising edge. in_ready = (level != DEPTH). There is no bypass; a push into a full FIFO cannot occur.
- Vector order is preserved FIFO-order. Within a vector, beats go out ch0, ch1, ch2, ch3.
- State machine, two states:
  - IDLE: out_valid=0. Moves to SEND when level != 0.
  - SEND: out_valid=1, presenting the head vector at channel ch_cnt.
- Beat handshake: out_valid && out_ready advances ch_cnt.
- On the ch3 beat, the head vector pops and ch_cnt wraps to 0. The FSM stays in SEND if another vector remains, giving back-to-back frames with no bubble. Otherwise it returns to IDLE.
- out_valid, out_data, out_ch and out_last are stable while out_valid && !out_ready.
- Scaling: s = y >>> SHIFT (sign-extending). out_data = s narrowed to OUT_W as set by configuration.
- Simultaneous push and ch3 pop in the same cycle: level is unchanged, and both occur. in_ready is evaluated from the pre-edge level, so a full FIFO refuses the push even if a pop happens in that cycle.
- Pointers wrap modulo DEPTH. level is held in a separate counter, so full and empty are unambiguous.

## Timing
- Reset (async assert, sync release) sets:
  - out_valid=0, out_data=0, out_ch=0, out_last=0.
  - level=0, sat_flag=0, FSM=IDLE, pointers=0.
  - in_ready=1 once reset is released.
- Latency: a vector pushed at edge N gives out_valid=1 with ch0 after edge N+1 when the FIFO was empty. Output is registered from FIFO storage.
- With out_ready held high, one vector occupies exactly 4 cycles. Sustained throughput is 1 vector per 4 cycles.
- Reset asserted mid-frame: the partial frame and all stored vectors are discarded. Nothing is replayed.

## Configuration
- ICA_OUT_SAT_EN defined:
  - s is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_flag is set on the first clipped beat that is handshaked.
  - sat_flag clears only on reset.
- ICA_OUT_SAT_EN undefined:
  - out_data is the low OUT_W bits of s (wrap).
  - sat_flag is constant 0.

## Structure
- Shared package ica_pkg holds ICA_DATA_W=26, ICA_NUM_CH=4, the state enum (IDLE, SEND), and the channel-index type.
- One sub-module: ica_vec_fifo. It is a DEPTH x 104-bit register FIFO with push/pop/level. The serializer FSM and scaler live in the top.

## Test plan
- Single vector y=(1024, -1024, 2048, 0), SHIFT=10, out_ready=1 → beats 1, -1, 2, 0 on out_ch 0..3. out_last only on the 4th beat. First beat appears 1 cycle after the push.
- Push 5 vectors back-to-back with out_ready=0, DEPTH=4 → in_ready drops after the 4th push and level=4. The 5th is held until the first frame's ch3 beat.
- out_ready toggling 1,0,1,0 → out_data and out_ch are held during stalls. Each vector completes in 8 cycles with no lost or duplicated beat.
- With ICA_OUT_SAT_EN, y1=2^25-1, SHIFT=0 → out_data=32767 and sat_flag=1. Without the macro → out_data=-1 (low 16 bits) and sat_flag=0.
- Full FIFO with a pop and in_valid in the same cycle → the push is refused, level goes from 4 to 3, and the push is accepted the next cycle.
- rst_n pulsed low mid-frame (after the ch1 beat) → outputs return to 0 immediately and level=0. The next push starts at ch0.
